// File: rtl/mips_alu_muldiv_if.sv
// Request/result bundle between EX-stage issue logic and the multiply/divide unit.
// Latency: none (wires only).
// Backpressure: issuer may only assert start while ready=1; busy mirrors the unit's state.
interface mips_alu_muldiv_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [2:0]        op;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic              cancel;
    logic              ready;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output start, op, data1, data2, cancel,
        input  ready, busy, done, hi, lo
    );

    modport slave (
        input  start, op, data1, data2, cancel,
        output ready, busy, done, hi, lo
    );
endinterface

// File: rtl/mips_alu_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning the architectural HI/LO registers.
// Latency: MUL 2 cycles accept->done (DATA_W+1 with MIPS_ALU_MULDIV_ITER_MUL_EN), DIV DATA_W+1, MT 0.
// Backpressure: ready=0 while an op is in flight; start is dropped (not queued) unless ready=1.
// Build option: define MIPS_ALU_MULDIV_ITER_MUL_EN for an iterative shift-add multiplier.
module mips_alu_muldiv #(
    parameter int DATA_W = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    mips_alu_muldiv_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    // Raw operands as captured at accept; a is also the div-by-zero HI value.
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    // Shared iteration pair: {remainder, quotient} for divide, {hi, lo} partial product for multiply.
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sgn_q, sgn_d;
    logic              is_div_q, is_div_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;

    logic              accept;
    logic              is_mul_op;
    logic              is_div_op;
    logic              is_signed_op;
    logic              last_iter;
    logic [DATA_W-1:0] dvs;
    logic [DATA_W:0]   rem_sh;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] res_hi;
    logic [DATA_W-1:0] res_lo;
`ifdef MIPS_ALU_MULDIV_ITER_MUL_EN
    logic [DATA_W:0]   sum;
`else
    logic [2*DATA_W-1:0] a_ext;
    logic [2*DATA_W-1:0] b_ext;
    logic [2*DATA_W-1:0] prod;
`endif

    // Magnitude of a value that is two's complement only when s is set.
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x, input logic s);
        return (s && x[DATA_W-1]) ? -x : x;
    endfunction

    // Cancel beats start in the same cycle, including MTHI/MTLO.
    assign accept       = (state_q == S_IDLE) && bus.start && !bus.cancel;
    assign is_mul_op    = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    assign is_div_op    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    assign is_signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign last_iter    = (cnt_q == CNT_ONE);
    assign dvs          = mag(b_q, sgn_q);

`ifndef MIPS_ALU_MULDIV_ITER_MUL_EN
    // Extending both operands to 2W bits makes a single unsigned multiply serve both signednesses.
    assign a_ext = {{DATA_W{sgn_q & a_q[DATA_W-1]}}, a_q};
    assign b_ext = {{DATA_W{sgn_q & b_q[DATA_W-1]}}, b_q};
    assign prod  = a_ext * b_ext;
`endif

    // State register; reset abandons any op in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            sgn_q    <= 1'b0;
            is_div_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            sgn_q    <= sgn_d;
            is_div_q <= is_div_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
        end
    end

    // Next state: iterate DATA_W times for DIV (and iterative MUL), one FIN cycle, flush on cancel.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && is_mul_op) begin
                    state_d = S_MUL;
                end else if (accept && is_div_op) begin
                    state_d = S_DIV;
                end
            end
            S_MUL: begin
`ifdef MIPS_ALU_MULDIV_ITER_MUL_EN
                if (last_iter) begin
                    state_d = S_FIN;
                end
`else
                state_d = S_FIN;
`endif
            end
            S_DIV: begin
                if (last_iter) begin
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.cancel && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    // Status outputs are registered copies of the next state so they leave the flops clean.
    always_comb begin
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_q == S_FIN) && !bus.cancel;
    end

    // Datapath: operand capture at accept, then one restoring-divide or shift-add step per cycle.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        sgn_d    = sgn_q;
        is_div_d = is_div_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        rem_sh   = {rem_q, quo_q[DATA_W-1]};
        diff     = rem_sh - {1'b0, dvs};
`ifdef MIPS_ALU_MULDIV_ITER_MUL_EN
        sum      = {1'b0, rem_q} + (quo_q[0] ? {1'b0, dvs} : '0);
`endif
        if (accept && (is_mul_op || is_div_op)) begin
            a_d      = bus.data1;
            b_d      = bus.data2;
            sgn_d    = is_signed_op;
            is_div_d = is_div_op;
            qneg_d   = is_signed_op && (bus.data1[DATA_W-1] ^ bus.data2[DATA_W-1]);
            rneg_d   = is_signed_op && bus.data1[DATA_W-1];
            rem_d    = '0;
            quo_d    = mag(bus.data1, is_signed_op);
            cnt_d    = CNT_INIT;
        end else if (state_q == S_DIV) begin
            cnt_d = cnt_q - CNT_ONE;
            // No borrow out of the trial subtract means the divisor fits: keep it, quotient bit 1.
            if (!diff[DATA_W]) begin
                rem_d = diff[DATA_W-1:0];
                quo_d = {quo_q[DATA_W-2:0], 1'b1};
            end else begin
                rem_d = rem_sh[DATA_W-1:0];
                quo_d = {quo_q[DATA_W-2:0], 1'b0};
            end
        end else if (state_q == S_MUL) begin
`ifdef MIPS_ALU_MULDIV_ITER_MUL_EN
            cnt_d = cnt_q - CNT_ONE;
            rem_d = sum[DATA_W:1];
            quo_d = {sum[0], quo_q[DATA_W-1:1]};
`else
            {rem_d, quo_d} = prod;
`endif
        end
    end

    // Final HI/LO: sign fix-up of magnitude results plus the divide-by-zero convention.
    always_comb begin
        res_hi = rem_q;
        res_lo = quo_q;
        if (is_div_q) begin
            if (b_q == '0) begin
                res_hi = a_q;
                res_lo = '1;
            end else begin
                // The -2^(W-1)/-1 case lands here naturally: magnitude 2^(W-1) reads back as itself.
                res_lo = qneg_q ? -quo_q : quo_q;
                res_hi = rneg_q ? -rem_q : rem_q;
            end
        end
`ifdef MIPS_ALU_MULDIV_ITER_MUL_EN
        else if (qneg_q) begin
            {res_hi, res_lo} = -{rem_q, quo_q};
        end
`endif
    end

    // HI/LO only move on an MT accept or when FIN completes without a flush.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (accept && (bus.op == OP_MTHI)) begin
            hi_d = bus.data1;
        end
        if (accept && (bus.op == OP_MTLO)) begin
            lo_d = bus.data1;
        end
        if ((state_q == S_FIN) && !bus.cancel) begin
            hi_d = res_hi;
            lo_d = res_lo;
        end
    end

    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule

// File: tb/tb_mips_alu_muldiv.sv
// Testbench for mips_alu_muldiv: 32-bit and 8-bit instances checked against a 64-bit arithmetic model.
// Latency: checks exact accept->done cycle counts.
// Backpressure: exercises start while busy, cancel, and start+cancel collisions.
module tb_mips_alu_muldiv;
    localparam int DIV_LAT32 = 33;
    localparam int DIV_LAT8  = 9;
`ifdef MIPS_ALU_MULDIV_ITER_MUL_EN
    localparam int MUL_LAT32 = 33;
    localparam int MUL_LAT8  = 9;
`else
    localparam int MUL_LAT32 = 2;
    localparam int MUL_LAT8  = 2;
`endif
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic clock = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    mips_alu_muldiv_if #(.DATA_W(32)) b32 ();
    mips_alu_muldiv_if #(.DATA_W(8))  b8 ();

    mips_alu_muldiv #(.DATA_W(32)) dut32 (.clock(clock), .reset_n(reset_n), .bus(b32));
    mips_alu_muldiv #(.DATA_W(8))  dut8  (.clock(clock), .reset_n(reset_n), .bus(b8));

    // Reference: plain 64-bit integer arithmetic on w-bit operands.
    function automatic void ref_model(input int w, input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] rhi, output logic [31:0] rlo);
        logic [63:0] m, ua, ub, t;
        longint sa, sb, q, r;
        m  = (64'd1 << w) - 64'd1;
        ua = {32'd0, a} & m;
        ub = {32'd0, b} & m;
        sa = ua[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
        sb = ub[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
        rhi = 32'd0;
        rlo = 32'd0;
        case (op)
            OP_MULT: begin
                t = sa * sb;
                rhi = 32'((t >> w) & m);
                rlo = 32'(t & m);
            end
            OP_MULTU: begin
                t = ua * ub;
                rhi = 32'((t >> w) & m);
                rlo = 32'(t & m);
            end
            OP_DIV: begin
                if (sb == 0) begin
                    rlo = 32'(m);
                    rhi = 32'(ua);
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    t = q;
                    rlo = 32'(t & m);
                    t = r;
                    rhi = 32'(t & m);
                end
            end
            default: begin
                if (ub == 0) begin
                    rlo = 32'(m);
                    rhi = 32'(ua);
                end else begin
                    rlo = 32'(ua / ub);
                    rhi = 32'(ua % ub);
                end
            end
        endcase
    endfunction

    task automatic drive(input int w, input logic st, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic cn);
        if (w == 8) begin
            b8.start = st; b8.op = op; b8.data1 = a[7:0]; b8.data2 = b[7:0]; b8.cancel = cn;
        end else begin
            b32.start = st; b32.op = op; b32.data1 = a; b32.data2 = b; b32.cancel = cn;
        end
    endtask

    function automatic logic get_done(input int w);
        return (w == 8) ? b8.done : b32.done;
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] msb;
        msb = 32'd1 << (w - 1);
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return msb;
            4:       return msb - 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Issue one op from idle, scramble operands after accept, wait for done (bounded).
    task automatic do_op(input int w, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] ohi, output logic [31:0] olo, output int lat);
        drive(w, 1'b1, op, a, b, 1'b0);
        @(posedge clock); #1;
        drive(w, 1'b0, 3'd0, $urandom, $urandom, 1'b0);
        lat = 0;
        while (!get_done(w) && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        ohi = (w == 8) ? {24'd0, b8.hi} : b32.hi;
        olo = (w == 8) ? {24'd0, b8.lo} : b32.lo;
    endtask

    task automatic test_reset();
        logic [31:0] h, l;
        int lat;
        reset_n = 1'b0;
        drive(32, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        drive(8, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        repeat (2) @(posedge clock); #1;
        checks++;
        if (b32.hi !== 32'd0 || b32.lo !== 32'd0 || b32.ready !== 1'b1 || b32.busy !== 1'b0 || b32.done !== 1'b0) begin
            errors++;
            $display("FAIL reset32: hi=%h lo=%h rdy=%b busy=%b done=%b, expected 0 0 1 0 0", b32.hi, b32.lo, b32.ready, b32.busy, b32.done);
        end
        checks++;
        if (b8.hi !== 8'd0 || b8.lo !== 8'd0 || b8.ready !== 1'b1 || b8.busy !== 1'b0 || b8.done !== 1'b0) begin
            errors++;
            $display("FAIL reset8: hi=%h lo=%h rdy=%b busy=%b done=%b, expected 0 0 1 0 0", b8.hi, b8.lo, b8.ready, b8.busy, b8.done);
        end
        reset_n = 1'b1;
        @(posedge clock); #1;
        drive(32, 1'b1, OP_MTHI, 32'hAAAA_5555, 32'd0, 1'b0);
        @(posedge clock); #1;
        drive(32, 1'b1, OP_DIV, 32'd100, 32'd7, 1'b0);
        @(posedge clock); #1;
        drive(32, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        repeat (10) @(posedge clock); #1;
        checks++;
        if (b32.busy !== 1'b1 || b32.hi !== 32'hAAAA_5555) begin
            errors++;
            $display("FAIL reset_pre: busy=%b hi=%h, expected 1 aaaa5555", b32.busy, b32.hi);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (b32.hi !== 32'd0 || b32.lo !== 32'd0 || b32.ready !== 1'b1 || b32.busy !== 1'b0 || b32.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: hi=%h lo=%h rdy=%b busy=%b done=%b, expected 0 0 1 0 0", b32.hi, b32.lo, b32.ready, b32.busy, b32.done);
        end
        @(posedge clock); #1;
        checks++;
        if (b32.done !== 1'b0 || b32.ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold: done=%b ready=%b, expected 0 1", b32.done, b32.ready);
        end
        reset_n = 1'b1;
        @(posedge clock); #1;
        do_op(32, OP_DIVU, 32'd100, 32'd7, h, l, lat);
        checks++;
        if (h !== 32'd2 || l !== 32'd14 || lat !== DIV_LAT32) begin
            errors++;
            $display("FAIL reset_after: hi=%h lo=%h lat=%0d, expected 2 e %0d", h, l, lat, DIV_LAT32);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_directed();
        logic [2:0]  ops [8] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_DIV, OP_DIV, OP_DIV, OP_DIVU};
        int          ws  [8] = '{32, 32, 32, 32, 32, 8, 8, 8};
        logic [31:0] as  [8] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'h80, 32'h85, 32'hF3};
        logic [31:0] bs  [8] = '{32'd3, 32'd3, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'hFF, 32'h00, 32'h00};
        logic [31:0] ehs [8] = '{32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'd7, 32'd0, 32'h00, 32'h85, 32'hF3};
        logic [31:0] els [8] = '{32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'h80, 32'hFF, 32'hFF};
        logic [31:0] h, l;
        int lat, elat;
        for (int i = 0; i < 8; i++) begin
            elat = (ops[i] < OP_DIV) ? ((ws[i] == 8) ? MUL_LAT8 : MUL_LAT32) : ws[i] + 1;
            do_op(ws[i], ops[i], as[i], bs[i], h, l, lat);
            checks++;
            if (h !== ehs[i] || l !== els[i] || lat !== elat) begin
                errors++;
                $display("FAIL directed[%0d]: hi=%h lo=%h lat=%0d, expected hi=%h lo=%h lat=%0d", i, h, l, lat, ehs[i], els[i], elat);
            end
            @(posedge clock); #1;
            checks++;
            if (get_done(ws[i]) !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse[%0d]: done=1 expected 0", i);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, h, l, eh, el;
        logic [2:0]  op;
        int w, lat, elat;
        for (int i = 0; i < 48; i++) begin
            w  = (i % 3 == 2) ? 8 : 32;
            op = 3'($urandom_range(0, 3));
            a  = pick(w);
            b  = pick(w);
            ref_model(w, op, a, b, eh, el);
            elat = (op < OP_DIV) ? ((w == 8) ? MUL_LAT8 : MUL_LAT32) : w + 1;
            do_op(w, op, a, b, h, l, lat);
            checks++;
            if (h !== eh || l !== el || lat !== elat) begin
                errors++;
                $display("FAIL random[%0d] w=%0d op=%0d a=%h b=%h: hi=%h lo=%h lat=%0d, expected hi=%h lo=%h lat=%0d",
                         i, w, op, a, b, h, l, lat, eh, el, elat);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_mt_back_to_back();
        logic quiet;
        quiet = 1'b1;
        drive(32, 1'b1, OP_MTHI, 32'h1234, 32'hFFFF, 1'b0);
        @(posedge clock); #1;
        if (b32.busy !== 1'b0 || b32.done !== 1'b0) quiet = 1'b0;
        checks++;
        if (b32.hi !== 32'h1234) begin
            errors++;
            $display("FAIL mthi: hi=%h expected 00001234", b32.hi);
        end
        drive(32, 1'b1, OP_MTLO, 32'h5678, 32'hFFFF, 1'b0);
        @(posedge clock); #1;
        drive(32, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (b32.busy !== 1'b0 || b32.done !== 1'b0 || b32.ready !== 1'b1) quiet = 1'b0;
            @(posedge clock); #1;
        end
        checks++;
        if (b32.hi !== 32'h1234 || b32.lo !== 32'h5678) begin
            errors++;
            $display("FAIL mtlo: hi=%h lo=%h expected 00001234 00005678", b32.hi, b32.lo);
        end
        checks++;
        if (quiet !== 1'b1) begin
            errors++;
            $display("FAIL mt_quiet: busy/done seen during MT, expected none");
        end
    endtask

    task automatic test_cancel();
        logic seen_done, hilo_ok;
        seen_done = 1'b0;
        hilo_ok   = 1'b1;
        drive(32, 1'b1, OP_DIVU, 32'd1000, 32'd3, 1'b0);
        @(posedge clock); #1;
        drive(32, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        repeat (9) @(posedge clock);
        #1;
        checks++;
        if (b32.busy !== 1'b1) begin
            errors++;
            $display("FAIL cancel_pre: busy=%b expected 1", b32.busy);
        end
        drive(32, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        @(posedge clock); #1;
        drive(32, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        checks++;
        if (b32.ready !== 1'b1 || b32.busy !== 1'b0) begin
            errors++;
            $display("FAIL cancel_ready: ready=%b busy=%b expected 1 0", b32.ready, b32.busy);
        end
        for (int i = 0; i < 40; i++) begin
            if (b32.done !== 1'b0) seen_done = 1'b1;
            if (b32.hi !== 32'h1234 || b32.lo !== 32'h5678) hilo_ok = 1'b0;
            @(posedge clock); #1;
        end
        checks++;
        if (seen_done !== 1'b0 || hilo_ok !== 1'b1) begin
            errors++;
            $display("FAIL cancel_result: done_seen=%b hilo_kept=%b hi=%h lo=%h, expected 0 1 00001234 00005678",
                     seen_done, hilo_ok, b32.hi, b32.lo);
        end
    endtask

    task automatic test_start_while_busy();
        int lat;
        logic extra;
        extra = 1'b0;
        drive(32, 1'b1, OP_DIVU, 32'd100, 32'd7, 1'b0);
        @(posedge clock); #1;
        drive(32, 1'b1, OP_MULT, 32'd5, 32'd6, 1'b0);
        lat = 0;
        while (!b32.done && lat < 100) begin
            @(posedge clock); #1;
            lat++;
            if (lat == 5) drive(32, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        end
        checks++;
        if (b32.hi !== 32'd2 || b32.lo !== 32'd14 || lat !== DIV_LAT32) begin
            errors++;
            $display("FAIL busy_start: hi=%h lo=%h lat=%0d, expected 2 e %0d", b32.hi, b32.lo, lat, DIV_LAT32);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (b32.done !== 1'b0 || b32.ready !== 1'b1 || b32.lo !== 32'd14) extra = 1'b1;
        end
        checks++;
        if (extra !== 1'b0) begin
            errors++;
            $display("FAIL busy_queue: dropped start produced activity (lo=%h), expected none", b32.lo);
        end
    endtask

    task automatic test_start_cancel_same();
        logic quiet;
        quiet = 1'b1;
        drive(32, 1'b1, OP_MTHI, 32'hDEAD, 32'd0, 1'b1);
        @(posedge clock); #1;
        checks++;
        if (b32.hi !== 32'd2) begin
            errors++;
            $display("FAIL cancel_mt: hi=%h expected 00000002", b32.hi);
        end
        drive(32, 1'b1, OP_MULT, 32'd3, 32'd4, 1'b1);
        @(posedge clock); #1;
        drive(32, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (b32.busy !== 1'b0 || b32.done !== 1'b0 || b32.lo !== 32'd14) quiet = 1'b0;
            @(posedge clock); #1;
        end
        checks++;
        if (quiet !== 1'b1) begin
            errors++;
            $display("FAIL cancel_start: op accepted despite cancel (busy=%b lo=%h), expected idle lo=0000000e", b32.busy, b32.lo);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_mt_back_to_back();
        test_cancel();
        test_start_while_busy();
        test_start_cancel_same();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_alu_muldiv.md
Name: mips_alu_muldiv

Overview:
- Multi-cycle multiply/divide unit with its own architectural HI/LO registers.
- Successor to the combinational ALU's MUL/MT paths; adds signed/unsigned division, which that ALU lacks.
- Sits beside the EX-stage ALU. Takes operands from EX, raises busy so hazard logic stalls MFHI/MFLO readers, and exposes hi/lo to the MEM-stage mux.

Parameters:
- DATA_W, 32, operand and HI/LO width; any even value >= 4.
- CNT_W, $clog2(DATA_W)+1, iteration counter width; derived, not overridden.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request valid; accepted only when ready=1.
- op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 reserved.
- data1  input  DATA_W  rs operand / dividend / MT source.
- data2  input  DATA_W  rt operand / divisor.
- cancel  input  1  pipeline flush of the in-flight op.
- ready  output  1  idle, can accept start.
- busy  output  1  =~ready; HI/LO pending.
- done  output  1  one-cycle pulse when HI/LO updated by MULT*/DIV*.
- hi  output  DATA_W  HI register.
- lo  output  DATA_W  LO register.

Behaviour:
- Clock and reset: one clock, clock; reset_n asynchronous active-low.
- Reset values: state=IDLE, hi=0, lo=0, ready=1, busy=0, done=0, counter=0. Reset mid-operation abandons the op immediately.
- States:
  - IDLE: start & op∈{MULT,MULTU} -> MUL.
  - IDLE: start & op∈{DIV,DIVU} -> DIV.
  - IDLE: MTHI/MTLO write hi/lo = data1 at the accepting edge and stay in IDLE. No done pulse, no busy.
  - IDLE: reserved op is ignored.
  - MUL and DIV run their iterations, then -> FIN.
  - FIN: write hi/lo, assert done for that cycle -> IDLE.
- Operand capture: operands are captured at the accept edge. Later changes on data1/data2 have no effect.
- MUL: single-cycle product computed in MUL state, so latency is 2 cycles from accept to done.
  - Signed: full 2*DATA_W two's-complement product.
  - {hi,lo} = product.
- DIV: radix-2 restoring divide on magnitudes, exactly DATA_W iterations, then FIN. Latency DATA_W+1 cycles from accept edge to done.
  - lo = quotient, truncated toward zero.
  - hi = remainder, sign follows the dividend (signed op).
  - Divisor 0: lo = all ones; hi = dividend. Terminates normally with no hang.
  - Signed overflow (-2^(W-1) / -1): lo = -2^(W-1), hi = 0.
- Start rules:
  - start while busy is ignored; no queuing.
  - start and cancel in the same IDLE cycle: cancel wins, nothing accepted.
- cancel while MUL, DIV or FIN: -> IDLE next edge. hi/lo unchanged, done not asserted.
- Timing: ready/busy are registered from state and combinational-free. done is registered.
- hi/lo change only at FIN or an MT accept edge.

Optional Feature:
- Macro: MIPS_ALU_MULDIV_ITER_MUL_EN.
- Defined:
  - MULT/MULTU use an iterative shift-add datapath on magnitudes, DATA_W iterations, then sign fix-up. Latency is DATA_W+1, identical to DIV.
  - No DATA_W x DATA_W multiplier is inferred.
- Undefined: single-cycle multiply as above, latency 2.
- Results are bit-identical in both builds.

Test Plan:
- Reset: hold reset_n=0 mid-DIV -> hi=lo=0, ready=1, done=0 while low; after release the unit accepts a new start.
- DATA_W=32:
  - MULT 0xFFFFFFFE × 3 -> done 2 cycles after accept (DATA_W+1=33 with ITER_MUL_EN); hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - MULTU, same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV -7/2 -> done exactly 33 cycles after accept; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 -> lo=0xFFFFFFFF, hi=7.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. Also check the signed-overflow and divide-by-zero cases with DATA_W=8.
- MTHI 0x1234 then MTLO 0x5678 on back-to-back cycles -> hi=0x1234, lo=0x5678, busy never asserted, no done. Then:
  - Start DIVU, assert cancel at iteration 10 -> ready next cycle, hi/lo still 0x1234/0x5678, no done.
  - start during busy -> ignored.
